// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback stage: register-file geometry and
// the {addr, data} request that flows through the MDU result buffer.
package wb_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests buffering MDU results until the
// register-file write port is free. Full/empty come from one extra pointer bit.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    i_push,
   input  wb_req_t i_push_req,
   input  logic    i_pop,
   output logic    o_full,
   output logic    o_empty,
   output wb_req_t o_head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0] r_wr_ptr;
   logic [PTR_W:0] r_rd_ptr;
   wb_req_t        r_mem [DEPTH];
   logic           w_do_push;
   logic           w_do_pop;

   // Same index with different wrap bits means the writer is a full lap ahead.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[PTR_W-1:0]] <= i_push_req;
      end
   end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: merges pipeline and MDU results onto the single register-file
// write port, with starvation-driven stalls. Optional bypass ports via WB_FWD_EN.
module writeback_unit
   import wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int STARVE_LIM = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_valid,
   input  logic [ADDR_W-1:0] pipe_addr,
   input  logic [DATA_W-1:0] pipe_data,
   input  logic              mdu_valid,
   output logic              mdu_ready,
   input  logic [ADDR_W-1:0] mdu_addr,
   input  logic [DATA_W-1:0] mdu_data,
   output logic              wb_stall,
   output logic              wb_err,
   output logic              reg_wr,
   output logic [ADDR_W-1:0] reg_wr_addr,
   output logic [DATA_W-1:0] reg_wr_data
`ifdef WB_FWD_EN
   ,
   output logic              fwd_valid,
   output logic [ADDR_W-1:0] fwd_addr,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);

   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_sel_valid;
   wb_req_t          w_head;
   wb_req_t          w_mdu_req;
   wb_req_t          w_sel_req;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] r_starve_cnt;

   assign w_mdu_req.addr = mdu_addr;
   assign w_mdu_req.data = mdu_data;
   assign mdu_ready      = !w_full;

   wb_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push    (mdu_valid),
      .i_push_req(w_mdu_req),
      .i_pop     (w_pop),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_head    (w_head)
   );

   // The pipe always wins the port; a stall only works because upstream obeys it.
   always_comb begin
      w_pop       = !w_empty && !pipe_valid;
      w_sel_valid = 1'b0;
      w_sel_req   = w_head;
      if (pipe_valid) begin
         w_sel_valid    = 1'b1;
         w_sel_req.addr = pipe_addr;
         w_sel_req.data = pipe_data;
      end else if (!w_empty) begin
         w_sel_valid = 1'b1;
      end
      w_cnt_next = (w_empty || w_pop) ? '0 : r_starve_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_wr       <= 1'b0;
         reg_wr_addr  <= '0;
         reg_wr_data  <= '0;
         wb_stall     <= 1'b0;
         wb_err       <= 1'b0;
         r_starve_cnt <= '0;
      end else begin
         reg_wr <= w_sel_valid && (w_sel_req.addr != ZERO_REG);
         if (w_sel_valid) begin
            reg_wr_addr <= w_sel_req.addr;
            reg_wr_data <= w_sel_req.data;
         end
         r_starve_cnt <= w_cnt_next;
         wb_stall     <= (w_cnt_next == CNT_W'(STARVE_LIM));
         if (wb_stall && pipe_valid) begin
            wb_err <= 1'b1;
         end
      end
   end

`ifdef WB_FWD_EN
   assign fwd_valid = reg_wr && (reg_wr_addr != ZERO_REG);
   assign fwd_addr  = reg_wr_addr;
   assign fwd_data  = reg_wr_data;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: directed scenario tasks plus a randomized run,
// all checked against a queue-based behavioural model of the writeback rules.
module tb_writeback_unit;

   localparam int DEPTH = 4;
   localparam int LIM   = 8;

   logic        clk;
   logic        rst_n;
   logic        pipe_valid;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data;
   logic        wb_stall;
   logic        wb_err;
   logic        reg_wr;
   logic [4:0]  reg_wr_addr;
   logic [31:0] reg_wr_data;
`ifdef WB_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;
`endif

   int testsRun;
   int testsFailed;

   // Model: queue of pending MDU results plus the visible output registers.
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   int          blocked;
   logic        expWr;
   logic [4:0]  expAddr;
   logic [31:0] expData;
   logic        expStall;
   logic        expErr;

   writeback_unit #(
      .FIFO_DEPTH(DEPTH),
      .STARVE_LIM(LIM)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pipe_valid (pipe_valid),
      .pipe_addr  (pipe_addr),
      .pipe_data  (pipe_data),
      .mdu_valid  (mdu_valid),
      .mdu_ready  (mdu_ready),
      .mdu_addr   (mdu_addr),
      .mdu_data   (mdu_data),
      .wb_stall   (wb_stall),
      .wb_err     (wb_err),
      .reg_wr     (reg_wr),
      .reg_wr_addr(reg_wr_addr),
      .reg_wr_data(reg_wr_data)
`ifdef WB_FWD_EN
      ,
      .fwd_valid  (fwd_valid),
      .fwd_addr   (fwd_addr),
      .fwd_data   (fwd_data)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic modelReset();
      mq.delete();
      blocked  = 0;
      expWr    = 1'b0;
      expAddr  = '0;
      expData  = '0;
      expStall = 1'b0;
      expErr   = 1'b0;
   endtask

   // Drives one cycle of inputs, advances the model, and returns #1 after the edge.
   task automatic applyStimulus(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                                input logic mv, input logic [4:0] ma, input logic [31:0] md);
      int   sizeBefore;
      bit   popped;
      bit   pushed;
      ent_t e;
      pipe_valid = pv;
      pipe_addr  = pa;
      pipe_data  = pd;
      mdu_valid  = mv;
      mdu_addr   = ma;
      mdu_data   = md;
      sizeBefore = mq.size();
      pushed     = mv && (sizeBefore < DEPTH);
      popped     = 0;
      if (pv) begin
         expWr   = (pa != 0);
         expAddr = pa;
         expData = pd;
         if (expStall) expErr = 1'b1;
      end else if (sizeBefore > 0) begin
         e       = mq.pop_front();
         popped  = 1;
         expWr   = (e.a != 0);
         expAddr = e.a;
         expData = e.d;
      end else begin
         expWr = 1'b0;
      end
      blocked  = (sizeBefore > 0 && !popped) ? blocked + 1 : 0;
      expStall = (blocked == LIM);
      if (pushed) begin
         e.a = ma;
         e.d = md;
         mq.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      repeat (DEPTH + 2) applyStimulus(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      modelReset();
      applyStimulus(0, 0, 0, 0, 0, 0);
      testsRun++; if (reg_wr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wr: got %0b want 0", reg_wr); end
      testsRun++; if (reg_wr_addr !== 5'd0) begin testsFailed++; $display("[TB] FAIL reset_addr: got %0d want 0", reg_wr_addr); end
      testsRun++; if (reg_wr_data !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_data: got %h want 0", reg_wr_data); end
      testsRun++; if (wb_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_stall: got %0b want 0", wb_stall); end
      testsRun++; if (wb_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %0b want 0", wb_err); end
      testsRun++; if (mdu_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ready: got %0b want 1", mdu_ready); end
      rst_n = 1'b1;
      modelReset();
   endtask

   task automatic test_pipe_write();
      drain();
      applyStimulus(1, 5'd3, 32'hDEADBEEF, 0, 0, 0);
      testsRun++; if (reg_wr !== 1'b1) begin testsFailed++; $display("[TB] FAIL pipe_wr: got %0b want 1", reg_wr); end
      testsRun++; if (reg_wr_addr !== 5'd3) begin testsFailed++; $display("[TB] FAIL pipe_addr: got %0d want 3", reg_wr_addr); end
      testsRun++; if (reg_wr_data !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL pipe_data: got %h want deadbeef", reg_wr_data); end
      applyStimulus(0, 0, 0, 0, 0, 0);
      testsRun++; if (reg_wr !== 1'b0) begin testsFailed++; $display("[TB] FAIL pipe_idle_wr: got %0b want 0", reg_wr); end
   endtask

   task automatic test_zero_addr();
      drain();
      applyStimulus(1, 5'd0, 32'h1234_5678, 0, 0, 0);
      testsRun++; if (reg_wr !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_pipe_wr: got %0b want 0", reg_wr); end
      applyStimulus(0, 0, 0, 1, 5'd0, 32'hCAFE_0000);
      testsRun++; if (reg_wr !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_push_wr: got %0b want 0", reg_wr); end
      applyStimulus(0, 0, 0, 0, 0, 0);
      testsRun++; if (reg_wr !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_pop_wr: got %0b want 0", reg_wr); end
      // A stuck entry would trip the starvation stall during this busy stretch.
      for (int i = 0; i < LIM + 1; i++) begin
         applyStimulus(1, 5'd5, $urandom, 0, 0, 0);
         testsRun++; if (wb_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_empty_stall[%0d]: got %0b want 0", i, wb_stall); end
      end
   endtask

   task automatic test_mdu_fill();
      logic [31:0] d[4];
      drain();
      for (int i = 0; i < 4; i++) begin
         d[i] = $urandom;
         applyStimulus(1, 5'd7, $urandom, 1, 5'(10 + i), d[i]);
         testsRun++; if (mdu_ready !== (i < 3)) begin testsFailed++; $display("[TB] FAIL fill_ready[%0d]: got %0b want %0b", i, mdu_ready, (i < 3)); end
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         testsRun++; if (reg_wr !== 1'b1 || reg_wr_addr !== 5'(10 + i) || reg_wr_data !== d[i]) begin
            testsFailed++;
            $display("[TB] FAIL fill_order[%0d]: got wr=%0b a=%0d d=%h want wr=1 a=%0d d=%h", i, reg_wr, reg_wr_addr, reg_wr_data, 10 + i, d[i]);
         end
      end
      drain();
      applyStimulus(0, 0, 0, 1, 5'd9, 32'hA5A5_0009);
      testsRun++; if (reg_wr !== 1'b0) begin testsFailed++; $display("[TB] FAIL latency_early: got %0b want 0", reg_wr); end
      applyStimulus(0, 0, 0, 0, 0, 0);
      testsRun++; if (reg_wr !== 1'b1 || reg_wr_addr !== 5'd9 || reg_wr_data !== 32'hA5A5_0009) begin
         testsFailed++;
         $display("[TB] FAIL latency_write: got wr=%0b a=%0d d=%h want wr=1 a=9 d=a5a50009", reg_wr, reg_wr_addr, reg_wr_data);
      end
   endtask

   task automatic test_starvation();
      drain();
      applyStimulus(1, 5'd1, $urandom, 1, 5'd17, 32'h0BAD_F00D);
      for (int i = 1; i <= LIM; i++) begin
         applyStimulus(1, 5'd1, $urandom, 0, 0, 0);
         testsRun++; if (wb_stall !== (i == LIM)) begin testsFailed++; $display("[TB] FAIL starve_stall[%0d]: got %0b want %0b", i, wb_stall, (i == LIM)); end
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      testsRun++; if (reg_wr !== 1'b1 || reg_wr_addr !== 5'd17 || reg_wr_data !== 32'h0BAD_F00D) begin
         testsFailed++;
         $display("[TB] FAIL starve_drain: got wr=%0b a=%0d d=%h want wr=1 a=17 d=0badf00d", reg_wr, reg_wr_addr, reg_wr_data);
      end
      testsRun++; if (wb_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL starve_one_cycle: got %0b want 0", wb_stall); end
      testsRun++; if (wb_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL starve_err: got %0b want 0", wb_err); end
   endtask

   task automatic test_stall_ignored();
      drain();
      applyStimulus(1, 5'd1, $urandom, 1, 5'd20, 32'h2020_2020);
      repeat (LIM) applyStimulus(1, 5'd1, $urandom, 0, 0, 0);
      testsRun++; if (wb_stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL ignore_stall: got %0b want 1", wb_stall); end
      applyStimulus(1, 5'd2, 32'h7777_1111, 0, 0, 0);
      testsRun++; if (reg_wr !== 1'b1 || reg_wr_addr !== 5'd2 || reg_wr_data !== 32'h7777_1111) begin
         testsFailed++;
         $display("[TB] FAIL ignore_pipe: got wr=%0b a=%0d d=%h want wr=1 a=2 d=77771111", reg_wr, reg_wr_addr, reg_wr_data);
      end
      testsRun++; if (wb_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL ignore_err_set: got %0b want 1", wb_err); end
      applyStimulus(0, 0, 0, 0, 0, 0);
      testsRun++; if (reg_wr !== 1'b1 || reg_wr_addr !== 5'd20 || reg_wr_data !== 32'h2020_2020) begin
         testsFailed++;
         $display("[TB] FAIL ignore_head_kept: got wr=%0b a=%0d d=%h want wr=1 a=20 d=20202020", reg_wr, reg_wr_addr, reg_wr_data);
      end
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);
      testsRun++; if (wb_err !== 1'b1) begin testsFailed++; $display("[TB] FAIL ignore_err_sticky: got %0b want 1", wb_err); end
   endtask

   task automatic test_reset_mid();
      drain();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 5'd4, $urandom, 1, 5'(24 + i), $urandom);
      end
      #2;
      rst_n = 1'b0;
      #1;
      testsRun++; if (reg_wr !== 1'b0 || reg_wr_addr !== 5'd0 || reg_wr_data !== 32'd0) begin
         testsFailed++;
         $display("[TB] FAIL midreset_outputs: got wr=%0b a=%0d d=%h want all 0", reg_wr, reg_wr_addr, reg_wr_data);
      end
      testsRun++; if (wb_err !== 1'b0 || wb_stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_flags: got err=%0b stall=%0b want 0 0", wb_err, wb_stall); end
      pipe_valid = 1'b0;
      mdu_valid  = 1'b0;
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      modelReset();
      @(posedge clk);
      #1;
      testsRun++; if (mdu_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL midreset_ready: got %0b want 1", mdu_ready); end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         testsRun++; if (reg_wr !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_stale[%0d]: got %0b want 0", i, reg_wr); end
      end
   endtask

   task automatic test_random();
      logic pv;
      for (int i = 0; i < 400; i++) begin
         pv = !expStall && ($urandom_range(0, 3) != 0);
         applyStimulus(pv, 5'($urandom_range(0, 31)), $urandom,
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
         testsRun++; if (reg_wr !== expWr) begin testsFailed++; $display("[TB] FAIL rand_wr[%0d]: got %0b want %0b", i, reg_wr, expWr); end
         if (expWr) begin
            testsRun++; if (reg_wr_addr !== expAddr || reg_wr_data !== expData) begin
               testsFailed++;
               $display("[TB] FAIL rand_payload[%0d]: got a=%0d d=%h want a=%0d d=%h", i, reg_wr_addr, reg_wr_data, expAddr, expData);
            end
         end
         testsRun++; if (wb_stall !== expStall) begin testsFailed++; $display("[TB] FAIL rand_stall[%0d]: got %0b want %0b", i, wb_stall, expStall); end
         testsRun++; if (wb_err !== expErr) begin testsFailed++; $display("[TB] FAIL rand_err[%0d]: got %0b want %0b", i, wb_err, expErr); end
         testsRun++; if (mdu_ready !== (mq.size() < DEPTH)) begin testsFailed++; $display("[TB] FAIL rand_ready[%0d]: got %0b want %0b", i, mdu_ready, (mq.size() < DEPTH)); end
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst_n       = 1'b0;
      pipe_valid  = 1'b0;
      pipe_addr   = '0;
      pipe_data   = '0;
      mdu_valid   = 1'b0;
      mdu_addr    = '0;
      mdu_data    = '0;
      modelReset();
      #1;
      test_reset();
      test_pipe_write();
      test_zero_addr();
      test_mdu_fill();
      test_starvation();
      test_stall_ignored();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
